// File: rtl/general_purpose_fifo.sv
// Single-clock 64-bit flit FIFO with registered read data and error flag.
// Ports: clk, reset (async active-low), write_en/data_in push,
// read_en pop to data_out (1-cycle latency), full/empty/ocup status,
// error pulses one cycle after a rejected access.
module general_purpose_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 16,
  parameter int PTR_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  error,
  output logic                  full,
  output logic                  empty,
  output logic [PTR_WIDTH:0]    ocup
);

  localparam logic [PTR_WIDTH:0] OcupFull =
    (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] OcupOne =
    (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH-1:0] PtrOne =
    PTR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH:0]    ocup_q, ocup_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  err_q, err_d;
  logic                  rd_ok, wr_ok;

  assign full  = (ocup_q == OcupFull);
  assign empty = (ocup_q == '0);

  // A read frees the head slot on the same edge,
  // so a full FIFO may still take a write.
  assign rd_ok = read_en && !empty;
  assign wr_ok = write_en && (!full || rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ocup_d   = ocup_q;
    dout_d   = dout_q;
    err_d    = (read_en && empty)
            || (write_en && !wr_ok);
    if (wr_ok) wr_ptr_d = wr_ptr_q + PtrOne;
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
      dout_d   = mem_q[rd_ptr_q];
    end
    unique case ({wr_ok, rd_ok})
      2'b10:   ocup_d = ocup_q + OcupOne;
      2'b01:   ocup_d = ocup_q - OcupOne;
      default: ocup_d = ocup_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ocup_q   <= '0;
      dout_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ocup_q   <= ocup_d;
      dout_q   <= dout_d;
      err_q    <= err_d;
    end
  end

  // Storage is not reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out = dout_q;
  assign error    = err_q;
  assign ocup     = ocup_q;

endmodule

// File: tb/tb_general_purpose_fifo.sv
// Scoreboard bench for general_purpose_fifo.
// Expected flits queued on accepted writes, popped on accepted reads.
module tb_general_purpose_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        write_en;
  logic        read_en;
  logic [63:0] data_in;
  logic [63:0] data_out;
  logic        error;
  logic        full;
  logic        empty;
  logic [4:0]  ocup;

  general_purpose_fifo dut (
    .clk      (clk),
    .reset    (reset),
    .write_en (write_en),
    .read_en  (read_en),
    .data_in  (data_in),
    .data_out (data_out),
    .error    (error),
    .full     (full),
    .empty    (empty),
    .ocup     (ocup)
  );

  always #5 clk = ~clk;

  logic [63:0] sb [$];
  logic [63:0] exp_do;
  logic        exp_err;
  int          checks;
  int          errors;

  task automatic drive(input logic we, input logic re,
                       input logic [63:0] d);
    logic rd_ok, wr_ok;
    write_en = we;
    read_en  = re;
    data_in  = d;
    rd_ok   = re && (sb.size() != 0);
    wr_ok   = we && (sb.size() < 16 || rd_ok);
    exp_err = (re && sb.size() == 0) || (we && !wr_ok);
    @(posedge clk);
    if (rd_ok) exp_do = sb.pop_front();
    if (wr_ok) sb.push_back(d);
    #1;
    write_en = 1'b0;
    read_en  = 1'b0;
  endtask

  task automatic test_reset();
    write_en = 1'b0;
    read_en  = 1'b0;
    data_in  = '0;
    reset    = 1'b0;
    #13;
    checks++;
    if (empty !== 1'b1) begin
      errors++; $display("FAIL reset_empty got %b want 1", empty);
    end
    checks++;
    if (full !== 1'b0) begin
      errors++; $display("FAIL reset_full got %b want 0", full);
    end
    checks++;
    if (ocup !== 5'd0) begin
      errors++; $display("FAIL reset_ocup got %0d want 0", ocup);
    end
    checks++;
    if (data_out !== 64'd0) begin
      errors++; $display("FAIL reset_dout got %h want 0", data_out);
    end
    checks++;
    if (error !== 1'b0) begin
      errors++; $display("FAIL reset_error got %b want 0", error);
    end
    reset   = 1'b1;
    exp_do  = '0;
    exp_err = 1'b0;
    sb.delete();
  endtask

  task automatic test_basic();
    logic [63:0] v [3];
    v[0] = 64'hA5A5A5A5A5A5A5A5;
    v[1] = 64'h00000000BBBBBBBB;
    v[2] = 64'h00010001BBBBBBBB;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, v[i]);
      checks++;
      if (ocup !== 5'(i + 1)) begin
        errors++;
        $display("FAIL basic_ocup got %0d want %0d", ocup, i + 1);
      end
    end
    drive(1'b0, 1'b1, '0);
    checks++;
    if (data_out !== 64'hA5A5A5A5A5A5A5A5 || data_out !== exp_do) begin
      errors++;
      $display("FAIL basic_dout got %h want %h", data_out, exp_do);
    end
    checks++;
    if (ocup !== 5'd2) begin
      errors++; $display("FAIL basic_ocup2 got %0d want 2", ocup);
    end
  endtask

  task automatic test_simultaneous();
    drive(1'b1, 1'b1, 64'h00010001CCCCCCCC);
    checks++;
    if (data_out !== 64'h00000000BBBBBBBB || data_out !== exp_do) begin
      errors++;
      $display("FAIL simul_dout got %h want %h", data_out, exp_do);
    end
    checks++;
    if (ocup !== 5'd2 || error !== 1'b0) begin
      errors++;
      $display("FAIL simul_ocup got %0d/%b want 2/0", ocup, error);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, '0);
      checks++;
      if (data_out !== exp_do) begin
        errors++;
        $display("FAIL simul_rd%0d got %h want %h", i, data_out, exp_do);
      end
    end
    checks++;
    if (data_out !== 64'h00010001CCCCCCCC) begin
      errors++;
      $display("FAIL simul_last got %h want 00010001cccccccc", data_out);
    end
    checks++;
    if (ocup !== 5'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL simul_empty got %0d/%b want 0/1", ocup, empty);
    end
  endtask

  task automatic test_underflow();
    drive(1'b0, 1'b1, '0);
    checks++;
    if (error !== 1'b1 || error !== exp_err) begin
      errors++; $display("FAIL uflow_err got %b want 1", error);
    end
    checks++;
    if (data_out !== exp_do || ocup !== 5'd0) begin
      errors++;
      $display("FAIL uflow_state got %h/%0d want %h/0",
               data_out, ocup, exp_do);
    end
    drive(1'b0, 1'b0, '0);
    checks++;
    if (error !== 1'b0) begin
      errors++; $display("FAIL uflow_pulse got %b want 0", error);
    end
    // Read+write while empty: write lands, read rejected.
    drive(1'b1, 1'b1, 64'h1234_5678_9ABC_DEF0);
    checks++;
    if (error !== 1'b1 || ocup !== 5'd1 || data_out !== exp_do) begin
      errors++;
      $display("FAIL empty_rw got %b/%0d/%h want 1/1/%h",
               error, ocup, data_out, exp_do);
    end
    drive(1'b0, 1'b1, '0);
    checks++;
    if (data_out !== 64'h1234_5678_9ABC_DEF0 || error !== 1'b0) begin
      errors++;
      $display("FAIL empty_rw_rd got %h/%b", data_out, error);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 16; i++)
      drive(1'b1, 1'b0, {$urandom, $urandom});
    checks++;
    if (full !== 1'b1 || ocup !== 5'd16 || empty !== 1'b0) begin
      errors++;
      $display("FAIL fill got full=%b ocup=%0d want 1/16", full, ocup);
    end
    drive(1'b1, 1'b0, 64'hDEAD_DEAD_DEAD_DEAD);
    checks++;
    if (error !== 1'b1 || ocup !== 5'd16) begin
      errors++;
      $display("FAIL oflow got err=%b ocup=%0d want 1/16", error, ocup);
    end
    drive(1'b0, 1'b0, '0);
    checks++;
    if (error !== 1'b0) begin
      errors++; $display("FAIL oflow_pulse got %b want 0", error);
    end
    drive(1'b1, 1'b1, 64'hFEED_FACE_0000_0001);
    checks++;
    if (error !== 1'b0 || ocup !== 5'd16 || full !== 1'b1) begin
      errors++;
      $display("FAIL full_rw got err=%b ocup=%0d want 0/16", error, ocup);
    end
    checks++;
    if (data_out !== exp_do) begin
      errors++;
      $display("FAIL full_rw_dout got %h want %h", data_out, exp_do);
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, '0);
      checks++;
      if (data_out !== exp_do) begin
        errors++;
        $display("FAIL drain%0d got %h want %h", i, data_out, exp_do);
      end
    end
    checks++;
    if (data_out !== 64'hFEED_FACE_0000_0001 || empty !== 1'b1) begin
      errors++;
      $display("FAIL drain_last got %h empty=%b", data_out, empty);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++)
      drive(1'b1, 1'b0, 64'(i) + 64'h100);
    for (int i = 3; i < 40; i++) begin
      drive(1'b1, 1'b1, 64'(i) + 64'h100);
      checks++;
      if (data_out !== exp_do || data_out !== 64'(i - 3) + 64'h100) begin
        errors++;
        $display("FAIL wrap%0d got %h want %h", i, data_out, exp_do);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, '0);
      checks++;
      if (data_out !== exp_do) begin
        errors++;
        $display("FAIL wrap_tail%0d got %h want %h", i, data_out, exp_do);
      end
    end
    checks++;
    if (data_out !== 64'h127 || ocup !== 5'd0) begin
      errors++;
      $display("FAIL wrap_end got %h/%0d want 127/0", data_out, ocup);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++)
      drive(1'b1, 1'b0, 64'hAB00 + 64'(i));
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (empty !== 1'b1 || ocup !== 5'd0 || full !== 1'b0) begin
      errors++;
      $display("FAIL midrst got empty=%b ocup=%0d want 1/0", empty, ocup);
    end
    checks++;
    if (data_out !== 64'd0 || error !== 1'b0) begin
      errors++;
      $display("FAIL midrst_out got %h/%b want 0/0", data_out, error);
    end
    sb.delete();
    exp_do  = '0;
    exp_err = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 1'b0, 64'h5555_AAAA_5555_AAAA);
    drive(1'b0, 1'b1, '0);
    checks++;
    if (data_out !== 64'h5555_AAAA_5555_AAAA || ocup !== 5'd0) begin
      errors++;
      $display("FAIL post_rst got %h/%0d", data_out, ocup);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_simultaneous();
    test_underflow();
    test_fill_overflow();
    test_wrap();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/general_purpose_fifo.md
Name: general_purpose_fifo

Overview:
Synchronous single-clock first-in/first-out buffer for 64-bit flits, used as the general-purpose queue inside the network interface and router buffers of the minimal NoC. Accepts one write and one read per cycle and provides full/empty status, an occupancy count and an error flag for illegal accesses. Read data is registered with one cycle of latency.

Parameters:
DATA_WIDTH, 64, width of data_in/data_out in bits
DEPTH, 16, number of storage entries (power of two)
PTR_WIDTH, 4, log2(DEPTH); ocup is PTR_WIDTH+1 bits wide

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
write_en  input  1  write request; data_in captured on rising edge
read_en  input  1  read request; head entry popped on rising edge
data_in  input  DATA_WIDTH  write data
data_out  output  DATA_WIDTH  registered read data
error  output  1  registered one-cycle flag for an illegal access
full  output  1  high when ocup == DEPTH
empty  output  1  high when ocup == 0
ocup  output  PTR_WIDTH+1  number of stored entries, range 0..DEPTH

Behaviour:
- Reset (reset==0, asynchronous, no clock needed): wr_ptr=0, rd_ptr=0, ocup=0, data_out=0, error=0; so empty=1, full=0. Memory contents need not be cleared. Reset asserted mid-operation discards all stored entries immediately.
- full and empty are combinational decodes of ocup; no lag behind ocup.
- Write accepted when write_en=1 and (full=0 or read accepted in the same cycle): mem[wr_ptr]<=data_in, wr_ptr increments modulo DEPTH.
- Read accepted when read_en=1 and empty=0: data_out<=mem[rd_ptr] on that edge; rd_ptr increments modulo DEPTH. Data appears on data_out one cycle after read_en is sampled.
- data_out holds its last value when no read is accepted.
- ocup: +1 on write-only accepted, -1 on read-only accepted, unchanged if both or neither accepted.
- Simultaneous read and write:
  - Not empty, not full: both happen; ocup unchanged.
  - Full: read pops the head, and the write is accepted into the freed slot. ocup stays DEPTH and error=0.
  - Empty: the write is accepted and the read is rejected. There is no fall-through: ocup becomes 1, data_out is unchanged, and error=1.
- Illegal access: a write while full with no accepted read, or a read while empty. The request is ignored (no pointer/ocup/memory change) and error=1 for the next cycle only. Otherwise error=0 each cycle.
- Pointers wrap from DEPTH-1 to 0 with no gap; FIFO order is preserved across the wrap.

Test Plan:
1. Reset: hold reset=0 for 10 ns, then release -> empty=1, full=0, ocup=0, data_out=0, error=0.
2. Basic order: write 64'hA5A5A5A5A5A5A5A5, 64'h00000000BBBBBBBB and 64'h00010001BBBBBBBB on three edges -> ocup=1,2,3. Then one read -> data_out=A5A5A5A5A5A5A5A5 the next cycle and ocup=2.
3. Simultaneous access: with ocup=2, assert read_en and write_en with data_in=64'h00010001CCCCCCCC -> data_out=00000000BBBBBBBB and ocup stays 2. Two further reads -> 00010001BBBBBBBB, then 00010001CCCCCCCC, with ocup=0 and empty=1.
4. Underflow: read while empty -> error=1 for one cycle; data_out, ocup and pointers unchanged.
5. Fill and overflow:
   - Write 16 words -> full=1 and ocup=16.
   - A 17th write -> error=1 for one cycle and is dropped.
   - Read+write while full -> error=0, ocup=16, and the head word is output.
6. Wrap-around and mid-operation reset:
   - Write and read 40 sequential values -> outputs in order across pointer wrap.
   - Assert reset mid-stream -> empty=1 and ocup=0 immediately, without waiting for a clock edge.
